// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer that owns the PC, issues one imem
// request at a time (req/gnt + rvalid) and hands each instruction to decode
// over a valid/ready handshake. Execute redirects override PC+4 stepping and
// squash whatever fetch is in flight.
//
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_squashed
// saturating event counters as extra output ports.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | imem_req asserted at imem_addr = pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid (drop = discard it)
// HOLD  | instruction presented to decode, waiting for dec_ready
module fetch_ctrl #(
  parameter int unsigned               PC_WIDTH    = 32,
  parameter int unsigned               INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]       RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_squashed,
`endif
  input  logic                   dec_ready
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MSK = ~PC_WIDTH'(3);

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic                   drop_q, drop_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;

  // Next-state logic: normal fetch loop first, redirect overrides on top.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          addr_d  = pc_q;
          pc_d    = pc_q + PC_INC;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = addr_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (instr_valid_q && dec_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      // Redirect target is word-aligned; the granted request (if any) still
      // completes on the bus, so it is marked for dropping.
      pc_d          = redirect_pc & ALIGN_MSK;
      instr_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (imem_gnt) drop_d = 1'b1;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            drop_d     = 1'b0;
            state_d    = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_HOLD: state_d = S_REQ;
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      addr_q        <= '0;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;
  logic        fetch_evt, squash_evt;

  // Event decode and saturating increment for the perf counters.
  always_comb begin
    fetch_evt  = (state_q == S_HOLD) && instr_valid_q && dec_ready && !redirect_valid;
    squash_evt = ((state_q == S_WAIT) && imem_rvalid && (drop_q || redirect_valid)) ||
                 ((state_q == S_HOLD) && instr_valid_q && redirect_valid);
    perf_fetched_d  = perf_fetched_q;
    perf_squashed_d = perf_squashed_q;
    if (fetch_evt && (perf_fetched_q != 32'hFFFF_FFFF))
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (squash_evt && (perf_squashed_q != 32'hFFFF_FFFF))
      perf_squashed_d = perf_squashed_q + 32'd1;
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with RESET_PC = 0x100 and a
// hand-driven zero-wait memory.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int checks = 0;
  int errors = 0;
  int exp_fetched = 0;

  fetch_ctrl #(
    .PC_WIDTH   (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed),
`endif
    .dec_ready     (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input int exp_f, input int exp_s);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetched"}, perf_fetched, 32'(exp_f));
    chk({tag, "_perf_squashed"}, perf_squashed, 32'(exp_s));
`else
    if (exp_f < 0 || exp_s < 0) $display("note: %s negative perf expectation", tag);
`endif
  endtask

  // One complete fetch from REQ at address a, decode stalled for hold cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int hold);
    logic [31:0] nxt;
    nxt = a + 32'd4;
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, a);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hX5A5_A5A5;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, d);
    chk("instr_pc", instr_pc, a);
    for (int i = 0; i < hold; i++) begin
      dec_ready = 1'b0;
      tick();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, d);
      chk("hold_pc", instr_pc, a);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    exp_fetched++;
    chk("consumed", {31'd0, instr_valid}, 32'd0);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, nxt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    dec_ready      = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk_perf("rst", 0, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Sequential fetches, third one stalled by decode for 5 cycles
    fetch(32'h100, 32'h1111_0001, 0);
    fetch(32'h104, 32'h1111_0002, 0);
    fetch(32'h108, 32'h1111_0003, 5);
    chk_perf("seq", 3, 0);

    // Redirect together with gnt at 0x10C
    chk("gnt_redir_addr", imem_addr, 32'h10C);
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    chk("gnt_redir_wait", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0001;
    tick();
    imem_rvalid = 1'b0;
    chk("gnt_redir_drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("gnt_redir_req", {31'd0, imem_req}, 32'd1);
    chk("gnt_redir_addr2", imem_addr, 32'h400);
    chk_perf("gnt_redir", 3, 1);

    // Redirect to unaligned 0x2002 while in WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    tick();
    redirect_valid = 1'b0;
    chk("wait_redir_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0002;
    tick();
    imem_rvalid = 1'b0;
    chk("wait_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("wait_redir_req2", {31'd0, imem_req}, 32'd1);
    chk_perf("wait_redir", 3, 2);
    fetch(32'h2000, 32'h2222_0000, 0);
    chk_perf("after_2000", 4, 2);

    // Redirect in HOLD with dec_ready=1: squash, no delivery
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3333_0004;
    tick();
    imem_rvalid = 1'b0;
    chk("hold_redir_pre", {31'd0, instr_valid}, 32'd1);
    chk("hold_redir_pc", instr_pc, 32'h2004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    dec_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h3000);
    chk_perf("hold_redir", 4, 3);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h4444_0000, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk_perf("wrap", exp_fetched, 3);

    // rst asserted while in WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("pre_rst_wait", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd1);
    chk("mid_rst_addr", imem_addr, 32'h100);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr_pc", instr_pc, 32'd0);
    chk_perf("mid_rst", 0, 0);
    fetch(32'h100, 32'h5555_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer owning the program counter.
- Issues one instruction-memory request at a time over a req/gnt + rvalid protocol and presents each fetched instruction to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which override sequential PC+4 stepping and squash in-flight fetches.
- Sits between the PC datapath and the imem port, ahead of decode.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports.
- INSTR_WIDTH, 32, width of fetched instruction word.
- RESET_PC, 0, PC value loaded on reset; low two bits must be 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  PC_WIDTH  target PC for redirect
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  INSTR_WIDTH  response instruction
- instr_valid  out  1  instruction available to decode
- instr  out  INSTR_WIDTH  fetched instruction
- instr_pc  out  PC_WIDTH  address of instr
- dec_ready  in  1  decode accepts instr this cycle

Behaviour:
- Reset:
  - state=REQ; pc=RESET_PC; drop=0; instr_valid=0; instr=0; instr_pc=0.
  - imem_req=1 in the first cycle after reset.
  - imem is reset by the same rst, so no stale response can arrive.
- Outputs: imem_req = (state==REQ); imem_addr = pc (registered). All other outputs are registered.
- States:
  - REQ: request asserted. If imem_gnt=1: addr_q<=pc, pc<=pc+4, go to WAIT. Otherwise stay in REQ.
  - WAIT: on imem_rvalid=1:
    - If drop=1: discard data, drop<=0, go to REQ.
    - Otherwise: instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1, go to HOLD.
  - HOLD: on instr_valid&&dec_ready: instr_valid<=0, go to REQ.
- Latency: gnt→rvalid is memory-defined. rvalid edge → instr_valid=1 next cycle. Consume edge → imem_req=1 next cycle. Minimum loop is 3 cycles per instruction with a zero-wait memory.
- At most one request outstanding. No new request while instr_valid=1.
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH. redirect_pc[1:0] is forced to 00 when loaded.
- Redirect has highest priority. On any cycle with redirect_valid=1:
  - pc <= redirect_pc.
  - instr_valid <= 0; the held instruction is squashed even if dec_ready=1 the same cycle.
  - REQ without gnt: stay in REQ. The new address appears next cycle; request withdrawal/retarget before gnt is permitted by the imem protocol.
  - REQ with gnt: go to WAIT with drop<=1; pc is the redirect target, not +4.
  - WAIT without rvalid: stay in WAIT, drop<=1.
  - WAIT with rvalid: discard data, go to REQ.
  - HOLD: go to REQ.
- imem_gnt and imem_rvalid are ignored outside REQ and WAIT respectively.
- rst mid-operation overrides everything: all state returns to reset values on the next edge.

Optional Feature:
- Macro: FETCH_PERF_EN
- When defined, adds output ports:
  - perf_fetched [31:0]: instructions delivered, i.e. instr_valid&&dec_ready with no redirect that cycle.
  - perf_squashed [31:0]: fetches discarded or squashed, counting dropped responses plus held instructions cleared by redirect.
- Both counters reset to 0, saturate at 0xFFFFFFFF, and update one cycle after the event.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0x100, zero-wait memory, dec_ready=1 → imem_addr sequence 0x100, 0x104, 0x108; instr_pc matches each address; one instruction per 3 cycles.
- Hold dec_ready=0 for 5 cycles while instr_valid=1 → instr/instr_pc stable, imem_req=0 throughout; on release, next request issued one cycle later.
- Redirect to 0x2002 while in WAIT → in-flight response discarded (instr_valid stays 0); next imem_addr=0x2000; delivered instr_pc=0x2000.
- Redirect to 0x400 in the same cycle as imem_gnt at 0x10C → response discarded; next request 0x400, not 0x110.
- Redirect in HOLD with dec_ready=1 → instr_valid drops, no delivery counted; with FETCH_PERF_EN, perf_squashed increments by 1.
- pc=0xFFFFFFFC fetched → next imem_addr=0x00000000; rst asserted in WAIT → next cycle state REQ, imem_addr=RESET_PC, instr_valid=0.
